cfo_phase_inc_writer: RTL
=========================

Name: cfo_phase_inc_writer

Overview:
- AXI4-Lite initiator that programs the phase-increment register (address 0x0) of the NCO CFO compensator's control port.
- Accepts phase-increment update requests from the CFO estimation path and coalesces requests that arrive while busy.
- Performs the AW/W/B transaction with a timeout and reports status, last committed value and a write count.

Parameters:
- ACC_WIDTH, 32, phase-increment width in bits; must be ≤ 32, zero-extended onto wdata.
- REG_ADDR, 4'h0, target register address driven on awaddr/araddr.
- TIMEOUT_CYCLES, 64, maximum cycles spent in any single bus-wait state before abort; ≥ 2.
- COUNT_WIDTH, 16, width of the successful-write counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  update request
- req_ready  out  1  always 1 when not in reset; request is never back-pressured
- req_phase_inc  in  ACC_WIDTH  requested phase increment
- m_axi_awvalid/awready/awaddr  out/in/out  1/1/4  write address channel
- m_axi_wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  write data channel
- m_axi_bvalid/bready/bresp  in/out/in  1/1/2  write response channel
- m_axi_arvalid/arready/araddr  out/in/out  1/1/4  read address channel, used only with the feature
- m_axi_rvalid/rready/rdata/rresp  in/out/in/in  1/1/32/2  read data channel, used only with the feature
- err_clear  in  1  clears all sticky error flags
- busy  out  1  FSM not IDLE
- wr_done  out  1  one-cycle pulse on a committed write
- wr_err  out  1  one-cycle pulse on a failed write
- err_timeout  out  1  sticky timeout flag
- err_resp  out  1  sticky non-OKAY bresp/rresp flag
- err_verify  out  1  sticky readback-mismatch flag
- last_phase_inc  out  ACC_WIDTH  last successfully committed value
- wr_count  out  COUNT_WIDTH  number of committed writes; wraps

Behaviour:
- Reset (sync, rst=1):
  - All valids = 0; bready = rready = 0; busy = 0; pulses = 0.
  - All sticky flags = 0; last_phase_inc = 0; wr_count = 0.
  - Pending slot empty; FSM = IDLE.
  - Reset mid-transaction drops the transaction with no completion pulse.
- Pending slot:
  - Any req_valid cycle loads pend_val ← req_phase_inc and sets pend = 1.
  - A newer request overwrites an older unlaunched one (latest wins).
- IDLE:
  - If pend = 1: latch cur ← pend_val, clear pend, go to ADDR_DATA next cycle.
  - A request arriving in the same cycle as launch becomes the new pending value, not lost.
- ADDR_DATA:
  - awvalid and wvalid rise together, in the cycle after launch.
  - awaddr = REG_ADDR; wdata = zero-extended cur; wstrb = 4'hF.
  - Each valid drops independently in the cycle after its own handshake (valid && ready).
  - When both handshakes are complete (same or different cycles): go to WAIT_B with bready = 1.
  - Addr/data stay stable while valid.
- WAIT_B, on bvalid:
  - bresp == 2'b00: with the feature, go to RD_ADDR. Without it: last_phase_inc ← cur, wr_count += 1, pulse wr_done next cycle, go to IDLE.
  - Otherwise: err_resp = 1, pulse wr_err, last_phase_inc unchanged, go to IDLE. No retry.
- Timeout:
  - Cycle counter resets on every state entry.
  - If it reaches TIMEOUT_CYCLES in ADDR_DATA, WAIT_B, RD_ADDR or RD_DATA: deassert all valids/readies, err_timeout = 1, pulse wr_err, go to IDLE.
  - This deliberate protocol abort is recovery-only.
- Pulses are mutually exclusive; at most one per transaction.
- Sticky flags clear on err_clear. If a set event coincides with err_clear, set wins.
- wr_count wraps from all-ones to 0.

Optional Feature:
- Macro: CFO_WRITER_READBACK_VERIFY_EN.
- Defined:
  - After an OKAY bresp, enter RD_ADDR: arvalid = 1, araddr = REG_ADDR, held until arready.
  - Then RD_DATA with rready = 1.
  - On rvalid: if rresp ≠ 0, err_resp = 1 and pulse wr_err.
  - Else if rdata[ACC_WIDTH-1:0] ≠ cur, err_verify = 1 and pulse wr_err.
  - Else commit exactly as on the success path (last_phase_inc, wr_count, wr_done).
- Undefined: arvalid tied 0, rready tied 0, err_verify tied 0; RD_* states absent.

Test Plan:
- Single write: req 0x01234567 → one AW(addr 0x0) + W(data 0x01234567, strb 0xF); after OKAY: wr_done once, last_phase_inc = 0x01234567, wr_count = 1, busy back to 0.
- Coalescing: requests A=0x10, B=0x20, C=0x30 on consecutive cycles, slow responder (3-cycle ready delay) → exactly two writes, A then C; wr_count = 2, last_phase_inc = 0x30.
- Split handshakes: awready in cycle N, wready in cycle N+3 → awvalid low from N+1, wvalid held until N+3, exactly one B accepted, wr_done once.
- Error response: bresp = 2'b10 → err_resp = 1, wr_err once, last_phase_inc and wr_count unchanged; err_clear → err_resp = 0.
- Timeout: TIMEOUT_CYCLES = 16, responder never asserts awready → valids drop after 16 cycles, err_timeout = 1, wr_err once; a following request completes normally.
- With the macro defined: readback returns 0xDEADBEEF after writing 0x00000100 → err_verify = 1, wr_err, no wr_done. A matching readback → wr_done, with the commit cycle after rvalid.

Source files
------------

// File: rtl/cfo_phase_inc_writer.sv
// rtl/cfo_phase_inc_writer.sv - AXI4-Lite initiator that commits coalesced NCO phase-increment updates.
// Optional readback verification is enabled by defining CFO_WRITER_READBACK_VERIFY_EN.
module cfo_phase_inc_writer #(
  parameter int          ACC_WIDTH      = 32,
  parameter logic [3:0]  REG_ADDR       = 4'h0,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ACC_WIDTH-1:0]   req_phase_inc,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [3:0]             m_axi_awaddr,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  output logic [31:0]            m_axi_wdata,
  output logic [3:0]             m_axi_wstrb,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  input  logic [1:0]             m_axi_bresp,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  output logic [3:0]             m_axi_araddr,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  input  logic [31:0]            m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic                   err_clear,
  output logic                   busy,
  output logic                   wr_done,
  output logic                   wr_err,
  output logic                   err_timeout,
  output logic                   err_resp,
  output logic                   err_verify,
  output logic [ACC_WIDTH-1:0]   last_phase_inc,
  output logic [COUNT_WIDTH-1:0] wr_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef CFO_WRITER_READBACK_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR_DATA, S_WAIT_B, S_RD_ADDR, S_RD_DATA} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ADDR_DATA, S_WAIT_B} state_t;
`endif

  state_t                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   pend_q, pend_d;
  logic [ACC_WIDTH-1:0]   pend_val_q, pend_val_d;
  logic [ACC_WIDTH-1:0]   cur_q, cur_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   bready_q, bready_d;
  logic                   wr_done_q, wr_done_d;
  logic                   wr_err_q, wr_err_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   err_resp_q, err_resp_d;
  logic [ACC_WIDTH-1:0]   last_q, last_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   launch, commit, fail_resp, abort, timeout_hit;
`ifdef CFO_WRITER_READBACK_VERIFY_EN
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic                   err_verify_q, err_verify_d;
  logic                   fail_verify;
`endif

  assign timeout_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q + TW'(1);
    pend_d        = pend_q;
    pend_val_d    = pend_val_q;
    cur_d         = cur_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    wr_done_d     = 1'b0;
    wr_err_d      = 1'b0;
    err_timeout_d = err_timeout_q & ~err_clear;
    err_resp_d    = err_resp_q & ~err_clear;
    last_d        = last_q;
    count_d       = count_q;
    launch        = 1'b0;
    commit        = 1'b0;
    fail_resp     = 1'b0;
    abort         = 1'b0;
`ifdef CFO_WRITER_READBACK_VERIFY_EN
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    err_verify_d  = err_verify_q & ~err_clear;
    fail_verify   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          launch    = 1'b1;
          cur_d     = pend_val_q;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_ADDR_DATA;
        end
      end
      S_ADDR_DATA: begin
        // AW and W retire independently; move on once neither is outstanding.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = S_WAIT_B;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      S_WAIT_B: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          if (m_axi_bresp == 2'b00) begin
`ifdef CFO_WRITER_READBACK_VERIFY_EN
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
`else
            commit = 1'b1;
`endif
          end else begin
            fail_resp = 1'b1;
          end
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
`ifdef CFO_WRITER_READBACK_VERIFY_EN
      S_RD_ADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          if (m_axi_rresp != 2'b00)                     fail_resp   = 1'b1;
          else if (m_axi_rdata[ACC_WIDTH-1:0] != cur_q) fail_verify = 1'b1;
          else                                          commit      = 1'b1;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      last_d    = cur_q;
      count_d   = count_q + COUNT_WIDTH'(1);
      wr_done_d = 1'b1;
      state_d   = S_IDLE;
    end
    if (fail_resp) begin
      err_resp_d = 1'b1;
      wr_err_d   = 1'b1;
      state_d    = S_IDLE;
    end
`ifdef CFO_WRITER_READBACK_VERIFY_EN
    if (fail_verify) begin
      err_verify_d = 1'b1;
      wr_err_d     = 1'b1;
      state_d      = S_IDLE;
    end
`endif
    if (abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
`ifdef CFO_WRITER_READBACK_VERIFY_EN
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
`endif
      err_timeout_d = 1'b1;
      wr_err_d      = 1'b1;
      state_d       = S_IDLE;
    end

    if (state_d != state_q) tcnt_d = '0;

    // A request in the launch cycle refills the slot rather than being dropped.
    if (launch) pend_d = 1'b0;
    if (req_valid) begin
      pend_d     = 1'b1;
      pend_val_d = req_phase_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      tcnt_q        <= '0;
      pend_q        <= 1'b0;
      pend_val_q    <= '0;
      cur_q         <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      wr_done_q     <= 1'b0;
      wr_err_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      err_resp_q    <= 1'b0;
      last_q        <= '0;
      count_q       <= '0;
`ifdef CFO_WRITER_READBACK_VERIFY_EN
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      err_verify_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      pend_q        <= pend_d;
      pend_val_q    <= pend_val_d;
      cur_q         <= cur_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      wr_done_q     <= wr_done_d;
      wr_err_q      <= wr_err_d;
      err_timeout_q <= err_timeout_d;
      err_resp_q    <= err_resp_d;
      last_q        <= last_d;
      count_q       <= count_d;
`ifdef CFO_WRITER_READBACK_VERIFY_EN
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      err_verify_q  <= err_verify_d;
`endif
    end
  end

  assign req_ready      = ~rst;
  assign m_axi_awvalid  = awvalid_q;
  assign m_axi_awaddr   = REG_ADDR;
  assign m_axi_wvalid   = wvalid_q;
  assign m_axi_wdata    = 32'(cur_q);
  assign m_axi_wstrb    = 4'hF;
  assign m_axi_bready   = bready_q;
  assign m_axi_araddr   = REG_ADDR;
  assign busy           = (state_q != S_IDLE);
  assign wr_done        = wr_done_q;
  assign wr_err         = wr_err_q;
  assign err_timeout    = err_timeout_q;
  assign err_resp       = err_resp_q;
  assign last_phase_inc = last_q;
  assign wr_count       = count_q;
`ifdef CFO_WRITER_READBACK_VERIFY_EN
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;
  assign err_verify     = err_verify_q;
`else
  assign m_axi_arvalid  = 1'b0;
  assign m_axi_rready   = 1'b0;
  assign err_verify     = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = &{1'b0, m_axi_arready, m_axi_rvalid, m_axi_rresp, m_axi_rdata};

endmodule
